// File: rtl/dmem_arbiter_if.sv
// Shared request/response types and the arbiter bus interface.
//
// mem_interface_pkg : mem_req_t (valid, we, addr, be, wdata) and mem_resp_t (ready, rvalid, rdata).
// dmem_arbiter_if   : bundles the NUM_PORTS requester-side channels and the single memory-side
//                     channel.
//   master : requester view (drives m_req, sees m_resp)
//   slave  : memory view (sees s_req, drives s_resp)
//   arb    : arbiter view (sees m_req/s_resp, drives m_resp/s_req)

package mem_interface_pkg;
   parameter int unsigned AddrWidth = 32;
   parameter int unsigned DataWidth = 32;
   parameter int unsigned BeWidth   = DataWidth / 8;

   typedef struct packed {
      logic                 valid;
      logic                 we;
      logic [AddrWidth-1:0] addr;
      logic [BeWidth-1:0]   be;
      logic [DataWidth-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic                 ready;
      logic                 rvalid;
      logic [DataWidth-1:0] rdata;
   } mem_resp_t;
endpackage

interface dmem_arbiter_if
   import mem_interface_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2
) ();
   mem_req_t  m_req  [NUM_PORTS];
   mem_resp_t m_resp [NUM_PORTS];
   mem_req_t  s_req;
   mem_resp_t s_resp;

   modport master (output m_req, input m_resp);
   modport slave  (input s_req, output s_resp);
   modport arb    (input m_req, output m_resp, output s_req, input s_resp);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between NUM_PORTS requesters.
// At most one beat is granted per cycle; the current owner keeps the grant for up to MAX_BURST
// consecutive beats while another port waits. The issuing port of each read is remembered so
// the one-cycle-latency read return is steered to that port only.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : arb modport; m_req/m_resp per requester, s_req/s_resp towards the memory

module dmem_arbiter
   import mem_interface_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned MAX_BURST = 4
) (
   input logic         clk_i,
   input logic         rst_ni,
   dmem_arbiter_if.arb bus
);

   localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);

   typedef logic [IdxW-1:0] idx_t;

   idx_t            owner_q, owner_d;
   idx_t            rd_owner_q, rd_owner_d;
   logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
   logic            rd_pending_q, rd_pending_d;

   logic [NUM_PORTS-1:0] valid, others_valid;
   idx_t                 grant, cand;
   int                   cand_int;
   logic                 grant_vld, accept;

   always_comb begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         valid[i] = bus.m_req[i].valid;
      end
   end

   // burst_cnt_q == 0 only right after reset: nobody holds the grant yet, so the wrap-around
   // search starting at owner+1 (port 0) decides, giving the lowest-numbered valid port.
   always_comb begin
      others_valid          = valid;
      others_valid[owner_q] = 1'b0;
      grant                 = owner_q;
      grant_vld             = 1'b0;
      cand                  = '0;
      cand_int              = 0;
      if ((burst_cnt_q != '0) && valid[owner_q] &&
          ((burst_cnt_q < CntW'(MAX_BURST)) || (others_valid == '0))) begin
         grant_vld = 1'b1;
      end else begin
         // k runs up to NUM_PORTS so the owner itself is the last candidate.
         for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            cand_int = int'(owner_q) + k;
            if (cand_int >= int'(NUM_PORTS)) cand_int = cand_int - int'(NUM_PORTS);
            cand = idx_t'(cand_int);
            if (!grant_vld && valid[cand]) begin
               grant_vld = 1'b1;
               grant     = cand;
            end
         end
      end
      if (!rst_ni) grant_vld = 1'b0;
   end

   assign accept = grant_vld && bus.s_resp.ready;

   always_comb begin
      bus.s_req = '0;
      if (grant_vld) bus.s_req = bus.m_req[grant];
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         bus.m_resp[i]        = '0;
         bus.m_resp[i].ready  = grant_vld && (grant == idx_t'(i)) && bus.s_resp.ready;
         bus.m_resp[i].rvalid = bus.s_resp.rvalid && rd_pending_q && (rd_owner_q == idx_t'(i));
         bus.m_resp[i].rdata  = bus.s_resp.rdata;
      end
   end

   always_comb begin
      owner_d      = owner_q;
      burst_cnt_d  = burst_cnt_q;
      rd_owner_d   = rd_owner_q;
      rd_pending_d = accept && !bus.s_req.we;
      if (accept) begin
         if (grant == owner_q) begin
            if (burst_cnt_q < CntW'(MAX_BURST)) burst_cnt_d = burst_cnt_q + 1'b1;
         end else begin
            owner_d     = grant;
            burst_cnt_d = CntW'(1);
         end
         if (!bus.s_req.we) rd_owner_d = grant;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q      <= idx_t'(NUM_PORTS - 1);
         burst_cnt_q  <= '0;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= '0;
      end else begin
         owner_q      <= owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// compared against a reference model built on the history of accepted ports.
module tb_dmem_arbiter;
   import mem_interface_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned MB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.NUM_PORTS(N)) bus ();

   dmem_arbiter #(.NUM_PORTS(N), .MAX_BURST(MB)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Memory with one-cycle read latency.
   logic [31:0] mem [256];
   logic        mem_ready = 1'b1;
   logic        force_rv  = 1'b0;
   logic        mem_rv_q  = 1'b0;
   logic [31:0] mem_rd_q  = '0;

   assign bus.s_resp = {mem_ready, mem_rv_q | force_rv, mem_rd_q};

   always @(posedge clk) begin
      mem_rv_q <= bus.s_req.valid && mem_ready && !bus.s_req.we;
      if (bus.s_req.valid && mem_ready) begin
         if (bus.s_req.we) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.s_req.be[b]) mem[bus.s_req.addr[9:2]][8*b +: 8] <= bus.s_req.wdata[8*b +: 8];
            end
         end else begin
            mem_rd_q <= mem[bus.s_req.addr[9:2]];
         end
      end
   end

   // Reference model state: list of accepted ports, plus the outstanding read.
   int          hist [$];
   int          pend_port = -1;
   logic [31:0] pend_data = '0;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] obs_rv;
   logic [31:0]  obs_rdata;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected grant from the round-robin/burst rules over the acceptance history.
   function automatic int exp_grant(input logic [N-1:0] v);
      int last, run, p;
      logic [N-1:0] others;
      if (v == '0) return -1;
      if (hist.size() == 0) begin
         for (int q = 0; q < int'(N); q++) if (v[q]) return q;
      end
      last = hist[hist.size() - 1];
      run  = 0;
      for (int j = hist.size() - 1; j >= 0 && run < int'(MB); j--) begin
         if (hist[j] != last) break;
         run++;
      end
      others       = v;
      others[last] = 1'b0;
      if (v[last] && (run < int'(MB) || others == '0)) return last;
      for (int k = 1; k <= int'(N); k++) begin
         p = (last + k) % int'(N);
         if (v[p]) return p;
      end
      return -1;
   endfunction

   task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
      mem_req_t r;
      r.valid = 1'b1;
      r.we    = we;
      r.addr  = addr;
      r.be    = be;
      r.wdata = wdata;
      bus.m_req[p] = r;
   endtask

   task automatic clear(input int p);
      bus.m_req[p] = '0;
   endtask

   // One clock cycle: inputs already applied; sample mid-cycle, then advance the model.
   task automatic step(output int acc, output int exp_acc);
      logic [N-1:0] v;
      int           g;
      mem_req_t     r;
      logic         exp_rv;
      #4;
      for (int i = 0; i < int'(N); i++) v[i] = bus.m_req[i].valid;
      g = rst_n ? exp_grant(v) : -1;
      acc = -1;
      for (int i = 0; i < int'(N); i++) begin
         check($sformatf("ready%0d", i), 96'(bus.m_resp[i].ready), 96'((g == i) && mem_ready));
         if (bus.m_resp[i].ready && v[i]) acc = i;
         exp_rv = rst_n && (pend_port == i) && bus.s_resp.rvalid;
         obs_rv[i] = bus.m_resp[i].rvalid;
         check($sformatf("rvalid%0d", i), 96'(bus.m_resp[i].rvalid), 96'(exp_rv));
         if (exp_rv) check($sformatf("rdata%0d", i), 96'(bus.m_resp[i].rdata), 96'(pend_data));
      end
      obs_rdata = bus.m_resp[0].rdata;
      r = (g >= 0) ? bus.m_req[g] : '0;
      check("s_req", 96'(bus.s_req), 96'(r));
      exp_acc = -1;
      if (!rst_n) begin
         hist.delete();
         pend_port = -1;
      end else begin
         pend_port = -1;
         if (g >= 0 && mem_ready) begin
            exp_acc = g;
            hist.push_back(g);
            if (!r.we) begin
               pend_port = g;
               pend_data = mem[r.addr[9:2]];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      int a, e;
      rst_n = 1'b0;
      step(a, e);
      rst_n = 1'b1;
   endtask

   int a, e;
   int burst_exp [7];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int p = 0; p < int'(N); p++) clear(p);

      // Reset: outputs quiet even with a request pending.
      step(a, e);
      set_req(0, 1'b0, 32'h40, 4'h0, 32'h0);
      step(a, e);
      check("rst_acc", 96'(a), 96'(-1));
      clear(0);
      rst_n = 1'b1;

      // Single-port write then read.
      set_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      step(a, e);
      check("t1_wr_acc", 96'(a), 96'(0));
      set_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
      step(a, e);
      check("t1_rd_acc", 96'(a), 96'(0));
      clear(0);
      step(a, e);
      check("t1_rv", 96'(obs_rv), 96'(2'b01));
      check("t1_rdata", 96'(obs_rdata), 96'(32'hDEADBEEF));
      step(a, e);
      check("t1_rv_idle", 96'(obs_rv), 96'(2'b00));

      // Simultaneous reads after reset.
      do_reset();
      mem[8'h08] = 32'h11111111;
      mem[8'h0C] = 32'h22222222;
      set_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
      set_req(1, 1'b0, 32'h30, 4'h0, 32'h0);
      step(a, e);
      check("t2_c0_acc", 96'(a), 96'(0));
      clear(0);
      step(a, e);
      check("t2_c1_acc", 96'(a), 96'(1));
      check("t2_c1_rv", 96'(obs_rv), 96'(2'b01));
      check("t2_c1_rdata", 96'(obs_rdata), 96'(32'h11111111));
      clear(1);
      step(a, e);
      check("t2_c2_rv", 96'(obs_rv), 96'(2'b10));
      check("t2_c2_rdata", 96'(obs_rdata), 96'(32'h22222222));

      // Burst limit: port 1 joins at cycle 2, gets cycle 4.
      do_reset();
      burst_exp = '{0, 0, 0, 0, 1, 0, 0};
      for (int c = 0; c < 7; c++) begin
         set_req(0, 1'b1, 32'h80 + 32'(c * 4), 4'hF, $urandom);
         if (c == 2) set_req(1, 1'b1, 32'h100, 4'hF, $urandom);
         step(a, e);
         check($sformatf("t3_c%0d_acc", c), 96'(a), 96'(burst_exp[c]));
         if (a == 1) clear(1);
      end
      clear(0);
      clear(1);

      // Memory stall.
      do_reset();
      set_req(0, 1'b1, 32'h44, 4'hF, $urandom);
      set_req(1, 1'b1, 32'h48, 4'hF, $urandom);
      step(a, e);
      check("t4_pre_acc", 96'(a), 96'(0));
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step(a, e);
         check($sformatf("t4_stall%0d_acc", c), 96'(a), 96'(-1));
         check($sformatf("t4_stall%0d_rv", c), 96'(obs_rv), 96'(2'b00));
      end
      mem_ready = 1'b1;
      step(a, e);
      check("t4_resume_acc", 96'(a), 96'(0));
      clear(0);
      clear(1);

      // Reset right after a port 1 read is accepted.
      do_reset();
      set_req(1, 1'b0, 32'h60, 4'h0, 32'h0);
      step(a, e);
      check("t5_rd_acc", 96'(a), 96'(1));
      clear(1);
      rst_n = 1'b0;
      step(a, e);
      check("t5_rst_rv", 96'(obs_rv), 96'(2'b00));
      rst_n = 1'b1;
      set_req(0, 1'b1, 32'h64, 4'hF, $urandom);
      set_req(1, 1'b1, 32'h68, 4'hF, $urandom);
      step(a, e);
      check("t5_tie_acc", 96'(a), 96'(0));
      check("t5_after_rv", 96'(obs_rv), 96'(2'b00));
      clear(0);
      clear(1);

      // Orphan return.
      force_rv = 1'b1;
      step(a, e);
      check("t6_orphan_rv", 96'(obs_rv), 96'(2'b00));
      force_rv = 1'b0;

      // Randomized traffic.
      for (int cyc = 0; cyc < 400; cyc++) begin
         mem_ready = ($urandom_range(0, 4) != 0);
         force_rv  = ($urandom_range(0, 9) == 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         for (int p = 0; p < int'(N); p++) begin
            if (!bus.m_req[p].valid && $urandom_range(0, 2) != 0) begin
               set_req(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                       4'($urandom), $urandom);
            end
         end
         step(a, e);
         check("rand_acc", 96'(a), 96'(e));
         if (e >= 0) clear(e);
      end
      force_rv = 1'b0;
      rst_n    = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-ported data memory between `NUM_PORTS` requesters, e.g. the pipeline load/store unit and a debug or DMA port. It sits between the requesters and the data memory and uses the `mem_req_t`/`mem_resp_t` types from `mem_interface_pkg` on both sides. It grants at most one request per cycle and enforces a per-owner burst limit for fairness. It tracks which port issued each read so the one-cycle-latency read return reaches only that port.

## Interface
- `NUM_PORTS`, default 2: number of requesters; minimum 2.
- `MAX_BURST`, default 4: maximum consecutive accepted beats for one port while another port is waiting; minimum 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = in reset).
- `m_req`  in  `mem_req_t [NUM_PORTS]`  requester-side requests (valid, we, addr, be, wdata).
- `m_resp`  out  `mem_resp_t [NUM_PORTS]`  requester-side responses (ready, rvalid, rdata).
- `s_req`  out  `mem_req_t`  request to the data memory.
- `s_resp`  in  `mem_resp_t`  response from the data memory.

## Operation
- **Handshake.**
  - A beat on port i is accepted when `m_req[i].valid && m_resp[i].ready`.
  - A requester holds valid and all request fields stable until its beat is accepted.
- **State.**
  - `owner`: last granted port, `clog2(NUM_PORTS)` bits.
  - `burst_cnt`: 0..MAX_BURST, saturating.
  - `rd_pending`: 1 bit.
  - `rd_owner`: port id of the pending read.
- **Grant selection** (combinational from state and current valids):
  - If `m_req[owner].valid` and (`burst_cnt < MAX_BURST` or no other port valid), grant `owner`.
  - Otherwise, search `owner+1, owner+2, …` modulo NUM_PORTS and grant the first valid port.
  - If no port is valid, there is no grant.
- **Forwarding.**
  - `s_req` equals `m_req[grant]`.
  - With no grant, `s_req.valid = 0` and all other `s_req` fields are 0.
  - `m_resp[i].ready = (grant == i) && s_resp.ready`. At most one ready is high in any cycle.
- **On an accepted beat from port g:**
  - If g == `owner`, `burst_cnt` increments, saturating at MAX_BURST.
  - If g != `owner`, `owner` becomes g and `burst_cnt` becomes 1.
- **Read tracking.**
  - Each cycle, `rd_pending <= accepted && !we`.
  - `rd_owner <= g` whenever a read is accepted.
  - Back-to-back reads from different ports therefore pipeline with no bubble.
- **Read return.**
  - `m_resp[i].rvalid = s_resp.rvalid && rd_pending && (rd_owner == i)`.
  - `m_resp[i].rdata = s_resp.rdata` on all ports; the value is meaningful only with rvalid.
  - `s_resp.rvalid` with `rd_pending = 0` is dropped and returned to no port.
- Writes produce no response beyond acceptance.
- **Reset.**
  - `owner = NUM_PORTS-1`, so port 0 wins the first arbitration.
  - `burst_cnt = 0`, `rd_pending = 0`, `rd_owner = 0`.
  - While `rst = 0`: `s_req` is all zeros and every `m_resp` ready and rvalid is 0.

## Timing
- Grant is combinational: request to `s_req` to `ready` all settle in the same cycle. There are no flops on the request path.
- Read data appears on `m_resp[rd_owner]` exactly one cycle after read acceptance, matching the memory's one-cycle read latency.
- `s_resp.ready = 0` stalls acceptance. No state changes except `rd_pending <= 0`.
- Fairness: with all ports continuously valid, each port gets MAX_BURST consecutive beats in rotation. A waiting port is granted within `(NUM_PORTS-1)*MAX_BURST` accepted beats.
- A lone requester is granted every cycle indefinitely; `burst_cnt` saturates.
- Reset asserted mid-read: the pending read is discarded and no rvalid is delivered. The first grant after deassertion goes to the lowest-numbered valid port.
- Simultaneous new request and read return to the same port: both are legal in one cycle. Ready and rvalid are independent.

## Test plan
- **Single-port write then read:**
  - Stimulus: port 0 writes 0xDEADBEEF to addr 0x10 with be = 0xF, then reads 0x10.
  - Required: ready high on both beats; port 0 rvalid one cycle after the read with rdata 0xDEADBEEF; port 1 rvalid stays 0.
- **Simultaneous reads after reset:**
  - Stimulus: both ports read different preloaded words in the same cycle.
  - Required: port 0 is accepted at cycle 0 and port 1 at cycle 1. Each port gets rvalid with its own data at cycles 1 and 2 respectively, never the other port's.
- **Burst limit, MAX_BURST = 4:**
  - Stimulus: port 0 requests continuously from cycle 0; port 1 asserts valid at cycle 2.
  - Required: port 0 is accepted at cycles 0–3, port 1 at cycle 4, port 0 again from cycle 5.
- **Memory stall:**
  - Stimulus: hold `s_resp.ready = 0` for 3 cycles with both ports valid.
  - Required: no acceptance, no rvalid, owner unchanged. After release, grant resumes per round-robin.
- **Reset mid-operation:**
  - Stimulus: assert `rst = 0` in the cycle after a port 1 read is accepted.
  - Required: no `m_resp` rvalid in any cycle. After deassertion, port 0 wins a tie.
- **Orphan return:**
  - Stimulus: force `s_resp.rvalid = 1` with no read accepted in the previous cycle.
  - Required: every `m_resp[i].rvalid` stays 0.
